// File: rtl/line_mem_responder.sv
// Responder for the 256-bit cache-line memory port: accepts one line request,
// waits a fixed latency, then completes it with a single-cycle ack.
module line_mem_responder #(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_e;

    localparam int            DEPTH  = 1 << ADDR_W;
    localparam logic [7:0]    LAT_M1 = 8'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [255:0]        wdata_q, wdata_d;
    logic                write_q, write_d;
    logic [255:0]        data_q, data_d;

    // Request that completes on this edge; with LATENCY=1 it comes straight
    // from the inputs rather than from the captured copy.
    logic                enter_ack;
    logic [ADDR_W-1:0]   ack_idx;
    logic                ack_write;
    logic [255:0]        ack_wdata;

    logic [ADDR_W-1:0]   req_idx;
    logic [255:0]        mem [DEPTH];

    assign req_idx = addr_i[ADDR_W+4:5];

    // Offset bits and bits above the line index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[4:0], addr_i[31:ADDR_W+5]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        enter_ack = 1'b0;
        ack_idx   = idx_q;
        ack_write = write_q;
        ack_wdata = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    idx_d   = req_idx;
                    wdata_d = data_i;
                    write_d = write_i;
                    cnt_d   = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                        ack_idx   = req_idx;
                        ack_write = write_i;
                        ack_wdata = data_i;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d   = S_ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        data_d = data_q;
        if (enter_ack && !ack_write) begin
            data_d = mem[ack_idx];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            data_q  <= data_d;
        end
    end

    // NOTE: the line array has no reset so it maps onto RAM and keeps its
    // contents across rst_i; the rst_i guard only blocks a commit while held.
    always_ff @(posedge clk_i) begin
        if (!rst_i && enter_ack && ack_write) begin
            mem[ack_idx] <= ack_wdata;
        end
    end

    assign ack_o  = (state_q == S_ACK);
    assign busy_o = (state_q != S_IDLE);
    assign data_o = data_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: default build (LATENCY=10) and a LATENCY=1 build
// share request inputs; a line model and read scoreboard supply expected data.
module tb_line_mem_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         wr;
    logic         en0, en1;
    logic         ack0, ack1, busy0, busy1;
    logic [255:0] rdata0, rdata1;

    int checks   = 0;
    int failures = 0;

    logic [255:0] model0 [int];
    logic [255:0] model1 [int];
    logic [255:0] sb [$];

    always #5 clk = ~clk;

    line_mem_responder #(.ADDR_W(9), .LATENCY(10)) dut0 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata),
        .enable_i(en0), .write_i(wr), .ack_o(ack0), .data_o(rdata0), .busy_o(busy0)
    );

    line_mem_responder #(.ADDR_W(9), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata),
        .enable_i(en1), .write_i(wr), .ack_o(ack1), .data_o(rdata1), .busy_o(busy1)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit           sel;       // 0 = LATENCY 10 build, 1 = LATENCY 1 build
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
        bit           scramble;  // disturb inputs and drop enable after acceptance
    } vec_t;

    // One complete request; inputs change #1 after rising edges, outputs are sampled there too.
    task automatic do_req(input vec_t v);
        int           idx;
        int           k;
        int           exp_lat;
        logic         a, b;
        logic [255:0] prev, got, e;
        idx     = int'(v.addr[13:5]);
        exp_lat = v.sel ? 0 : 10;
        prev    = v.sel ? rdata1 : rdata0;
        addr    = v.addr;
        wdata   = v.data;
        wr      = v.wr;
        if (v.sel) en1 = 1'b1; else en0 = 1'b1;
        if (!v.wr) begin
            if (v.sel) sb.push_back(model1[idx]); else sb.push_back(model0[idx]);
        end
        @(posedge clk); #1;
        check("busy_after_accept", {255'd0, v.sel ? busy1 : busy0}, 256'd1);
        if (v.scramble) begin
            addr  = ~v.addr;
            wdata = ~v.data;
            wr    = ~v.wr;
            en0   = 1'b0;
        end
        k = 0;
        a = v.sel ? ack1 : ack0;
        while (!a && k < 100) begin
            @(posedge clk); #1;
            k++;
            a = v.sel ? ack1 : ack0;
        end
        if (!a) check("ack_timeout", 256'd0, 256'd1);
        check("ack_latency", 256'(k), 256'(exp_lat));
        got = v.sel ? rdata1 : rdata0;
        if (!v.wr) begin
            if (sb.size() == 0) begin
                check("scoreboard_empty", 256'd0, 256'd1);
            end else begin
                e = sb.pop_front();
                check("read_data", got, e);
            end
        end else begin
            check("write_holds_data_o", got, prev);
            if (v.sel) model1[idx] = v.data; else model0[idx] = v.data;
        end
        // enable is still high for non-scrambled requests: no accept may happen in ACK
        @(posedge clk); #1;
        a = v.sel ? ack1 : ack0;
        b = v.sel ? busy1 : busy0;
        check("closing_edge_idle", {254'd0, a, b}, 256'd0);
        en0 = 1'b0;
        en1 = 1'b0;
    endtask

    vec_t vecs [12];

    initial begin
        logic seen_ack;
        vecs[0]  = '{0, 1, 32'h0000_0420, {8{32'hDEADBEEF}}, 0};
        vecs[1]  = '{0, 0, 32'h0000_0420, '0, 0};
        vecs[2]  = '{0, 1, 32'h0000_0040, {4{64'h0123_4567_89AB_CDEF}}, 0};
        vecs[3]  = '{0, 0, 32'h0000_005C, '0, 0};
        vecs[4]  = '{0, 0, 32'h0000_4040, '0, 0};
        vecs[5]  = '{0, 1, 32'h0000_0800, {8{32'hA5A5_0F0F}}, 1};
        vecs[6]  = '{0, 0, 32'h0000_0800, '0, 0};
        vecs[7]  = '{0, 0, 32'h0000_0420, 256'h1, 1};
        vecs[8]  = '{0, 0, 32'h0000_0040, '0, 0};
        vecs[9]  = '{1, 1, 32'h0000_0060, {8{32'h1357_9BDF}}, 0};
        vecs[10] = '{1, 0, 32'h0000_0060, '0, 0};
        vecs[11] = '{1, 0, 32'h0000_4060, '0, 0};

        rst = 1'b1; addr = '0; wdata = '0; wr = 1'b0; en0 = 1'b0; en1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("in_reset", {253'd0, ack0, busy0, ack1}, 256'd0);
        rst = 1'b0;

        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("idle_ack_busy", {254'd0, ack0, busy0}, 256'd0);
            check("idle_data", rdata0, 256'd0);
        end
        check("idle_dut1", {254'd0, ack1, busy1}, 256'd0);

        for (int i = 0; i < 9; i++) do_req(vecs[i]);

        // Abort a write by reset in WAIT; line 3 must keep its earlier contents.
        do_req('{0, 1, 32'h0000_0060, {8{32'hCAFE_F00D}}, 0});
        addr = 32'h0000_0060; wdata = '1; wr = 1'b1; en0 = 1'b1;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_reset_outputs", {254'd0, ack0, busy0}, 256'd0);
        check("mid_reset_data", rdata0, 256'd0);
        en0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        seen_ack = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (ack0 || busy0) seen_ack = 1'b1;
        end
        check("no_ack_after_abort", {255'd0, seen_ack}, 256'd0);
        do_req('{0, 0, 32'h0000_0060, '0, 0});

        for (int i = 9; i < 12; i++) do_req(vecs[i]);

        check("scoreboard_drained", 256'(sb.size()), 256'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Responder end of the 256-bit cache-line memory interface driven by the data cache (addr/data/enable/write out, data/ack back).
- Accepts one line request at a time, models fixed main-memory latency with a counter, then completes the request with a single-cycle ack.
- Read requests return the addressed line on data_o; write requests commit data_i to the addressed line.
- Sits between the dcache memory port and the top level; drop-in target for the CPU's mem_* ports.

Parameters:
- ADDR_W, 9, line-index width; depth = 2^ADDR_W lines of 32 bytes (default 16 KiB).
- LATENCY, 10, clock edges from request acceptance to ack; legal range 1..255.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- addr_i  in  32  byte address of the request; line index = addr_i[ADDR_W+4:5]; addr_i[4:0] and bits above ADDR_W+4 ignored.
- data_i  in  256  write line data, sampled at acceptance.
- enable_i  in  1  request valid; initiator holds it high until it sees ack_o.
- write_i  in  1  1 = write, 0 = read; sampled at acceptance.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  256  read line data; valid in the ack_o cycle of a read.
- busy_o  out  1  high from acceptance until the end of the ack_o cycle.

Behaviour:
- Reset (asynchronous, rst_i high): state=IDLE, ack_o=0, busy_o=0, data_o=0, counter=0, captured request cleared. Memory array is not reset; contents are preserved across reset, undefined at power-up, and bench-loadable via $readmemh.
- States: IDLE, WAIT, ACK.
- IDLE: at a rising edge with enable_i=1, accept. Latch line index, data_i, and write_i. Load counter=LATENCY-1. Set busy_o=1. Go to WAIT, or go straight to ACK if LATENCY=1. enable_i=0 leaves the block in IDLE.
- WAIT: decrement the counter each edge; at counter==0, go to ACK. Edge-count rule: ack_o is high during the cycle that begins exactly LATENCY edges after the acceptance edge.
- Entering ACK (registered on the same edge):
  - ack_o=1.
  - Read: data_o = mem[captured index].
  - Write: mem[captured index] = captured data; data_o holds its previous value.
- ACK lasts exactly one cycle. At its closing edge: ack_o=0, busy_o=0, state=IDLE. enable_i is not sampled in the ACK cycle, so no back-to-back request is accepted there. Minimum spacing between acceptances is LATENCY+1 edges.
- Request stability:
  - addr_i, data_i, and write_i changes after acceptance have no effect.
  - enable_i dropping during WAIT does not cancel the request; ack_o still fires.
- data_o holds its last value between acks. Only read completions update it.
- Read-after-write to the same line returns the newly written data, because the write committed in the earlier ACK cycle.
- Address wrap: indices alias modulo 2^ADDR_W, e.g. addr 0x0000_4000 maps to line 0 with ADDR_W=9.
- Reset mid-operation (WAIT or ACK): return to IDLE immediately with ack_o=0 and busy_o=0. A pending write that has not reached ACK is discarded, leaving memory unchanged. A write already in its ACK cycle has already committed.
- No X propagation: ack_o and busy_o are always 0/1 after reset.

Test Plan:
- Reset then idle: rst_i pulse, enable_i=0 for 20 cycles -> ack_o=0, busy_o=0, data_o=0 throughout.
- Write then read: write addr 0x0000_0420 with data {8{32'hDEADBEEF}}, then read the same addr -> each ack_o exactly 10 edges after its acceptance. The read returns data_o={8{32'hDEADBEEF}} in the ack cycle. Total 22 cycles with enable re-asserted immediately after each ack.
- Offset/alias: write line at 0x0000_0040, read 0x0000_005C and 0x0000_4040 -> both return the written line.
- Request hold and input changes: after acceptance, toggle addr_i, data_i, and write_i, and drop enable_i in WAIT -> ack still at edge +10, acting on the originally captured request only.
- LATENCY=1 build: read request -> ack_o in the cycle immediately after the acceptance edge; busy_o high for exactly 1 cycle.
- Reset mid-write: accept a write of all-ones to line 3, assert rst_i at edge +5 -> ack_o never fires, state IDLE. A subsequent read of line 3 returns its pre-write value.
